// File: rtl/reaction_pkg.sv
// Shared definitions for the reflex-game reaction timer: state encoding,
// BCD saturation value and the default 1 ms prescaler divide.
package reaction_pkg;

    localparam int          TICK_DIV_DEFAULT = 50000;
    localparam logic [15:0] BCD_MAX          = 16'h9999;

    typedef logic [2:0] state_t;

    localparam state_t ST_IDLE   = 3'd0;
    localparam state_t ST_ARMED  = 3'd1;
    localparam state_t ST_TIMING = 3'd2;
    localparam state_t ST_DONE   = 3'd3;
    localparam state_t ST_EARLY  = 3'd4;
    localparam state_t ST_TOUT   = 3'd5;

endpackage

// File: rtl/bcd_counter_4d.sv
// Four-digit BCD up-counter with synchronous clear; saturates at 9999.
// Also used by the score display.
module bcd_counter_4d
    import reaction_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        clr,
    input  logic        inc,
    output logic [15:0] q,
    output logic        at_max
);

    logic [15:0] q_q;
    logic [15:0] q_d;
    logic        carry;

    assign q      = q_q;
    assign at_max = (q_q == BCD_MAX);

    // Ripple a decimal carry up from the units digit.
    always_comb begin
        q_d   = q_q;
        carry = 1'b1;
        if (clr) begin
            q_d = '0;
        end else if (inc && !at_max) begin
            for (int i = 0; i < 4; i++) begin
                if (carry) begin
                    if (q_q[4*i +: 4] == 4'd9) begin
                        q_d[4*i +: 4] = 4'd0;
                    end else begin
                        q_d[4*i +: 4] = q_q[4*i +: 4] + 4'd1;
                        carry         = 1'b0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            q_q <= '0;
        end else begin
            q_q <= q_d;
        end
    end

endmodule

// File: rtl/reaction_timer.sv
// Reaction timer: armed by load_rand, counts ms from the LED rising to a new
// button press, flags false starts/timeouts and keeps the best time.
module reaction_timer
    import reaction_pkg::*;
#(
    parameter int TICK_DIV = TICK_DIV_DEFAULT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        load_rand,
    input  logic        led,
    input  logic        btn,
    output logic [15:0] time_bcd,
    output logic [15:0] best_bcd,
    output logic        done,
    output logic        early,
    output logic        timeout,
    output logic [2:0]  dbg_state
);

    localparam int          PW   = $clog2(TICK_DIV);
    localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

    state_t          state_q, state_d;
    logic [PW-1:0]   presc_q, presc_d;
    logic [15:0]     best_q, best_d;
    logic            best_valid_q, best_valid_d;
    logic            btn_q, led_q;
    logic            btn_rise, led_rise, tick;
    logic            cnt_clr, cnt_inc, cnt_at_max;

    assign btn_rise = btn & ~btn_q;
    assign led_rise = led & ~led_q;
    assign tick     = (state_q == ST_TIMING) && (presc_q == LAST);

    bcd_counter_4d u_count (
        .clk    (clk),
        .reset  (reset),
        .clr    (cnt_clr),
        .inc    (cnt_inc),
        .q      (time_bcd),
        .at_max (cnt_at_max)
    );

    always_comb begin
        state_d      = state_q;
        presc_d      = presc_q;
        best_d       = best_q;
        best_valid_d = best_valid_q;
        cnt_clr      = 1'b0;
        cnt_inc      = 1'b0;

        if (state_q == ST_TIMING) begin
            presc_d = tick ? '0 : presc_q + PW'(1);
        end

        if (load_rand) begin
            state_d = ST_ARMED;
            cnt_clr = 1'b1;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_ARMED: begin
                    if (btn_rise) begin
                        state_d = ST_EARLY;
                    end else if (led_rise) begin
                        state_d = ST_TIMING;
                        presc_d = '0;
                    end
                end
                ST_TIMING: begin
                    // A press on a tick edge wins and the tick is dropped.
                    if (btn_rise) begin
                        state_d = ST_DONE;
                    end else if (tick) begin
                        if (cnt_at_max) state_d = ST_TOUT;
                        else            cnt_inc = 1'b1;
                    end
                end
                ST_DONE: begin
                    // time_bcd is frozen here, so repeating the compare is harmless.
                    if (!best_valid_q || (time_bcd < best_q)) begin
                        best_d = time_bcd;
                    end
                    best_valid_d = 1'b1;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        btn_q <= btn;
        led_q <= led;
        if (reset) begin
            state_q      <= ST_IDLE;
            presc_q      <= '0;
            best_q       <= BCD_MAX;
            best_valid_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            presc_q      <= presc_d;
            best_q       <= best_d;
            best_valid_q <= best_valid_d;
        end
    end

    assign best_bcd  = best_q;
    assign done      = (state_q == ST_DONE);
    assign early     = (state_q == ST_EARLY);
    assign timeout   = (state_q == ST_TOUT);
    assign dbg_state = state_q;

endmodule

// File: tb/tb_reaction_timer.sv
// Randomised scoreboard bench for reaction_timer with TICK_DIV=4.
module tb_reaction_timer;

    localparam int TD = 4;
    localparam logic [2:0] K_DONE  = 3'b100;
    localparam logic [2:0] K_EARLY = 3'b010;
    localparam logic [2:0] K_TOUT  = 3'b001;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        load_rand = 1'b0;
    logic        led = 1'b0;
    logic        btn = 1'b0;
    logic [15:0] time_bcd, best_bcd;
    logic        done, early, timeout;
    logic [2:0]  dbg_state;

    int n_checks = 0;
    int n_pass   = 0;
    int best_ms  = 9999;
    logic [34:0] exp_q[$];

    always #5 clk = ~clk;

    reaction_timer #(.TICK_DIV(TD)) dut (
        .clk       (clk),
        .reset     (reset),
        .load_rand (load_rand),
        .led       (led),
        .btn       (btn),
        .time_bcd  (time_bcd),
        .best_bcd  (best_bcd),
        .done      (done),
        .early     (early),
        .timeout   (timeout),
        .dbg_state (dbg_state)
    );

    function automatic logic [15:0] to_bcd(input int v);
        to_bcd = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic pulse_load();
        @(negedge clk) load_rand = 1'b1;
        @(negedge clk) load_rand = 1'b0;
    endtask

    // Press lands d edges after the edge that sees the LED rise.
    // Result = ticks strictly before the press edge = (d-1)/TD ms.
    task automatic round_timed(input int d, input bit held);
        int n;
        if (held) btn = 1'b1;
        pulse_load();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        led = 1'b1;
        n = (d - 1) / TD;
        if (n >= 10000) begin
            exp_q.push_back({K_TOUT, 16'h9999, to_bcd(best_ms)});
        end else begin
            if (n < best_ms) best_ms = n;
            exp_q.push_back({K_DONE, to_bcd(n), to_bcd(best_ms)});
        end
        for (int i = 0; i < d; i++) begin
            @(negedge clk);
            if (i == 0 && held) btn = 1'b0;
        end
        btn = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        led = 1'b0;
    endtask

    task automatic round_early(input bit same);
        pulse_load();
        repeat ($urandom_range(0, 3)) @(negedge clk);
        btn = 1'b1;
        if (same) led = 1'b1;
        exp_q.push_back({K_EARLY, 16'h0000, to_bcd(best_ms)});
        repeat (3) @(negedge clk);
        led = 1'b1;
        repeat (3) @(negedge clk);
        btn = 1'b0;
        led = 1'b0;
    endtask

    // Monitor: pops one expectation each time a result flag comes up; the
    // best time is compared one cycle later.
    bit          seen = 1'b0;
    bit          best_pending = 1'b0;
    logic [15:0] best_exp;
    always @(negedge clk) begin
        logic [34:0] e;
        if (best_pending) begin
            check("best_bcd", best_bcd, best_exp);
            best_pending = 1'b0;
        end
        if ((done | early | timeout) && !seen) begin
            seen = 1'b1;
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_result: flags %b with nothing expected", {done, early, timeout});
            end else begin
                e = exp_q.pop_front();
                check("flags", {13'b0, done, early, timeout}, {13'b0, e[34:32]});
                check("time_bcd", time_bcd, e[31:16]);
                best_exp     = e[15:0];
                best_pending = 1'b1;
            end
        end
        if (!(done | early | timeout)) seen = 1'b0;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("%0d/%0d checks passed", n_pass, n_checks + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (3) @(negedge clk);
        check("rst_time", time_bcd, 16'h0000);
        check("rst_best", best_bcd, 16'h9999);
        check("rst_flags", {13'b0, done, early, timeout}, 16'h0000);
        check("rst_state", {13'b0, dbg_state}, 16'h0000);
        reset = 1'b0;
        repeat (2) @(negedge clk);

        round_timed(50, 0);    // 0012
        round_timed(101, 0);   // 0025, best stays 0012
        round_timed(21, 0);    // 0005, new best
        round_early(0);
        round_early(1);
        round_timed(41, 0);    // 0010
        pulse_load();
        check("load_in_done_time", time_bcd, 16'h0000);
        check("load_in_done_best", best_bcd, to_bcd(best_ms));
        check("load_in_done_state", {13'b0, dbg_state}, 16'h0001);
        round_timed(401, 0);   // 0100
        round_timed(4001, 0);  // 1000
        round_timed(30, 1);    // held button ignored; new press gives 0007
        round_timed(4, 0);     // press on the first tick edge: suppressed -> 0000

        for (int r = 0; r < 16; r++) begin
            case ($urandom_range(0, 4))
                0, 1: round_timed($urandom_range(3, 120), 0);
                2:    round_early(0);
                3:    round_early(1);
                default: round_timed($urandom_range(3, 60), 1);
            endcase
        end

        // Reset abandons a round in progress.
        pulse_load();
        led = 1'b1;
        repeat (10) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_time", time_bcd, 16'h0000);
        check("midrst_best", best_bcd, 16'h9999);
        check("midrst_flags", {13'b0, done, early, timeout}, 16'h0000);
        check("midrst_state", {13'b0, dbg_state}, 16'h0000);
        reset = 1'b0;
        led   = 1'b0;
        best_ms = 9999;
        repeat (2) @(negedge clk);
        round_timed(60, 0);    // 0014, first best after reset

        round_timed(40010, 0); // no press in time -> timeout, late press ignored
        check("tout_after_press_flag", {15'b0, timeout}, 16'h0001);
        check("tout_after_press_time", time_bcd, 16'h9999);

        for (int i = 0; i < 20 && (exp_q.size() != 0 || best_pending); i++) @(negedge clk);
        if (exp_q.size() != 0) begin
            n_checks++;
            $display("FAIL drain: %0d results never presented, expected 0", exp_q.size());
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
